booth_mac_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiply-accumulate unit. It is the successor to the fixed 8-bit multiplier and adds:
- configurable operand width;
- signed/unsigned mode selected per operation;
- a valid/ready input handshake and a one-cycle result strobe;
- a wide accumulator with clear and sticky overflow.

It sits between the operand sequencer and the MAC result path.

---
 rtl/booth_mac_seq.sv | 169 ++++++++++++++++
 tb/tb_booth_mac_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_seq.sv
// booth_mac_seq: sequential radix-2 Booth multiply-accumulate unit.
// One operand set is accepted in IDLE. WIDTH+1 Booth steps run in RUN.
// DONE strobes out_valid while the product is folded into a wide accumulator
// that carries a sticky overflow flag.
module booth_mac_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic                 acc_en,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   prod,
    output logic [ACC_W-1:0]     acc,
    output logic                 overflow
);

    localparam int unsigned OW    = WIDTH + 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [OW-1:0]      m_r;
    logic [OW-1:0]      a_r;
    logic [OW-1:0]      q_r;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;
    logic               sgn_r;
    logic               acc_en_r;

    logic [OW-1:0]      ext_a_c;
    logic [OW-1:0]      ext_b_c;
    logic               booth_add_c;
    logic               booth_sub_c;
    logic [OW-1:0]      addend_c;
    logic [OW-1:0]      sum_c;
    logic [OW-1:0]      a_nxt_c;
    logic [OW-1:0]      q_nxt_c;
    logic [PW-1:0]      prod_nxt_c;
    logic [ACC_W-1:0]   pext_c;
    logic [ACC_W:0]     acc_sum_c;
    logic               acc_ovf_c;
    logic               last_c;

    // Operand extension to WIDTH+1 bits so one datapath serves both modes
    always_comb begin
        ext_a_c = {is_signed & a[WIDTH-1], a};
        ext_b_c = {is_signed & b[WIDTH-1], b};
    end

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {A,Q,Q_1}
    always_comb begin
        booth_add_c = ~q_r[0] & q_1;
        booth_sub_c = q_r[0] & ~q_1;
        addend_c    = '0;
        if (booth_add_c) begin
            addend_c = m_r;
        end else if (booth_sub_c) begin
            addend_c = ~m_r;
        end
        sum_c      = a_r + addend_c + OW'(booth_sub_c);
        a_nxt_c    = {sum_c[OW-1], sum_c[OW-1:1]};
        q_nxt_c    = {sum_c[0], q_r[OW-1:1]};
        prod_nxt_c = PW'({a_nxt_c, q_nxt_c});
    end

    // Product extension to accumulator width and the add with its overflow detect
    always_comb begin
        pext_c = ACC_W'(prod_nxt_c);
        if (sgn_r && prod_nxt_c[PW-1]) begin
            pext_c = pext_c | ~(ACC_W'({PW{1'b1}}));
        end
        acc_sum_c = {1'b0, acc} + {1'b0, pext_c};
        if (sgn_r) begin
            acc_ovf_c = (acc[ACC_W-1] == pext_c[ACC_W-1]) &&
                        (acc_sum_c[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            acc_ovf_c = acc_sum_c[ACC_W];
        end
        last_c = (state == RUN) && (cnt == CNT_W'(WIDTH));
    end

    // Control FSM and Booth iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            m_r       <= '0;
            a_r       <= '0;
            q_r       <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
            sgn_r     <= 1'b0;
            acc_en_r  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_r      <= ext_a_c;
                        q_r      <= ext_b_c;
                        a_r      <= '0;
                        q_1      <= 1'b0;
                        cnt      <= '0;
                        sgn_r    <= is_signed;
                        acc_en_r <= acc_en;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_r <= a_nxt_c;
                    q_r <= q_nxt_c;
                    q_1 <= q_r[0];
                    cnt <= cnt + CNT_W'(1);
                    if (last_c) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Result, accumulator and sticky overflow; clr coinciding with completion loads the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod     <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else if (last_c) begin
            prod <= prod_nxt_c;
            if (clr) begin
                acc      <= pext_c;
                overflow <= 1'b0;
            end else if (acc_en_r) begin
                acc      <= acc_sum_c[ACC_W-1:0];
                overflow <= overflow | acc_ovf_c;
            end else begin
                acc <= pext_c;
            end
        end else if (clr) begin
            acc      <= '0;
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Bench for booth_mac_seq: two instances (24-bit and 16-bit accumulators)
// share one stimulus stream and are checked against an arithmetic model.
module tb_booth_mac_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         acc_en;
    logic         clr;

    logic         in_ready, out_valid, overflow;
    logic [15:0]  prod;
    logic [23:0]  acc;
    logic         r16, v16, ov16;
    logic [15:0]  p16;
    logic [15:0]  acc16;

    int total = 0;
    int bad   = 0;

    // model state: index 0 = 24-bit accumulator, 1 = 16-bit accumulator
    longint macc [2];
    bit     movf [2];

    typedef struct {
        longint p;
        bit     s;
        bit     en;
    } op_t;

    booth_mac_seq #(.WIDTH(W), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .clr(clr),
        .out_valid(out_valid), .prod(prod), .acc(acc), .overflow(overflow)
    );

    booth_mac_seq #(.WIDTH(W), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16),
        .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .clr(clr),
        .out_valid(v16), .prod(p16), .acc(acc16), .overflow(ov16)
    );

    always #5 clk = ~clk;

    // exact mathematical product of the operands as interpreted by mode
    function automatic longint prod_of(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        if (s) return longint'($signed(x)) * longint'($signed(y));
        return longint'(x) * longint'(y);
    endfunction

    // accumulator rules applied with plain integer arithmetic
    task automatic model_op(input longint p, input bit s, input bit en, input bit c);
        for (int i = 0; i < 2; i++) begin
            longint md, half, pu, sum, sacc, r;
            md   = longint'(1) << ((i == 0) ? 24 : 16);
            half = md / 2;
            pu   = ((p % md) + md) % md;
            if (c) begin
                macc[i] = pu;
                movf[i] = 1'b0;
            end else if (en) begin
                sum = macc[i] + pu;
                if (s) begin
                    sacc = (macc[i] >= half) ? macc[i] - md : macc[i];
                    r    = sacc + p;
                    if (r < -half || r >= half) movf[i] = 1'b1;
                end else if (sum >= md) begin
                    movf[i] = 1'b1;
                end
                macc[i] = sum % md;
            end else begin
                macc[i] = pu;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
        end
    endtask

    // drive one operation; lat = edges from accept edge to first out_valid sample
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit s,
                          input bit en, input bit c, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        a = x; b = y; is_signed = s; acc_en = en; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        is_signed = 1'($urandom);
        acc_en    = 1'($urandom);
        for (int i = 1; i <= 40; i++) begin
            clr = c && (i == int'(W) + 1);
            @(posedge clk); #1;
            clr = 1'b0;
            if (out_valid === 1'b1) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (prod !== 16'h0) begin bad++; $display("FAIL reset_prod got=%h want=0", prod); end
        total++; if (acc !== 24'h0 || acc16 !== 16'h0) begin bad++; $display("FAIL reset_acc got=%h/%h want=0", acc, acc16); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_unsigned_full();
        bit ok; int lat;
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'hFF, 8'hFF, 1'b0), 1'b0, 1'b0, 1'b0);
        total++; if (!ok || lat != int'(W) + 1) begin bad++; $display("FAIL ufull_latency got=%0d ok=%b want=%0d", lat, ok, W + 1); end
        total++; if (prod !== 16'hFE01) begin bad++; $display("FAIL ufull_prod got=%h want=fe01", prod); end
        total++; if (acc !== 24'h00FE01) begin bad++; $display("FAIL ufull_acc got=%h want=00fe01", acc); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ufull_strobe_width got=%b want=0", out_valid); end
    endtask

    task automatic test_signed();
        bit ok; int lat;
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'h80, 8'h80, 1'b1), 1'b1, 1'b0, 1'b0);
        total++; if (!ok || prod !== 16'h4000) begin bad++; $display("FAIL signed_min_prod got=%h ok=%b want=4000", prod, ok); end
        run_op(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'hFD, 8'h05, 1'b1), 1'b1, 1'b0, 1'b0);
        total++; if (!ok || prod !== 16'hFFF1) begin bad++; $display("FAIL signed_neg_prod got=%h ok=%b want=fff1", prod, ok); end
        total++; if (acc !== 24'hFFFFF1) begin bad++; $display("FAIL signed_neg_acc got=%h want=fffff1", acc); end
    endtask

    task automatic test_accum_chain();
        bit ok; int lat;
        logic [W-1:0] z;
        run_op(8'd7, 8'd6, 1'b1, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'd7, 8'd6, 1'b1), 1'b1, 1'b0, 1'b0);
        total++; if (acc !== 24'd42) begin bad++; $display("FAIL chain_load got=%0d want=42", acc); end
        run_op(8'hFD, 8'h05, 1'b1, 1'b1, 1'b0, ok, lat);
        model_op(prod_of(8'hFD, 8'h05, 1'b1), 1'b1, 1'b1, 1'b0);
        total++; if (acc !== 24'd27) begin bad++; $display("FAIL chain_add_neg got=%0d want=27", acc); end
        z = W'($urandom);
        run_op(8'd0, z, 1'b1, 1'b1, 1'b0, ok, lat);
        model_op(prod_of(8'd0, z, 1'b1), 1'b1, 1'b1, 1'b0);
        total++; if (acc !== 24'd27 || overflow !== 1'b0) begin bad++; $display("FAIL chain_add_zero got=%0d ovf=%b want=27 ovf=0", acc, overflow); end
    endtask

    task automatic test_overflow_clr();
        bit ok; int lat;
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'hFF, 8'hFF, 1'b0), 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, ok, lat);
        model_op(prod_of(8'hFF, 8'hFF, 1'b0), 1'b0, 1'b1, 1'b0);
        total++; if (acc16 !== 16'hFC02 || ov16 !== 1'b1) begin bad++; $display("FAIL ovf_set got=%h ovf=%b want=fc02 ovf=1", acc16, ov16); end
        total++; if (acc !== 24'(macc[0]) || overflow !== movf[0]) begin bad++; $display("FAIL ovf_wide got=%h ovf=%b want=%h ovf=%b", acc, overflow, 24'(macc[0]), movf[0]); end
        run_op(8'd1, 8'd1, 1'b0, 1'b1, 1'b0, ok, lat);
        model_op(prod_of(8'd1, 8'd1, 1'b0), 1'b0, 1'b1, 1'b0);
        total++; if (ov16 !== 1'b1 || acc16 !== 16'hFC03) begin bad++; $display("FAIL ovf_sticky got=%h ovf=%b want=fc03 ovf=1", acc16, ov16); end
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        total++; if (acc16 !== 16'h0 || ov16 !== 1'b0 || acc !== 24'h0) begin bad++; $display("FAIL clr_alone got=%h/%h ovf=%b want=0", acc16, acc, ov16); end
        run_op(8'd2, 8'd3, 1'b0, 1'b1, 1'b1, ok, lat);
        model_op(prod_of(8'd2, 8'd3, 1'b0), 1'b0, 1'b1, 1'b1);
        total++; if (!ok || acc16 !== 16'd6 || acc !== 24'd6 || ov16 !== 1'b0) begin bad++; $display("FAIL clr_with_done got=%0d/%0d ovf=%b want=6", acc16, acc, ov16); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa [3];
        logic [W-1:0] sb [3];
        bit           ss [3];
        op_t          pend[$];
        op_t          op;
        int           pulses[$];
        int           nacc;
        bit           acc_now;
        bit           prev_v;
        sa[0] = 8'd12;  sb[0] = 8'd34;  ss[0] = 1'b0;
        sa[1] = 8'hF0;  sb[1] = 8'h11;  ss[1] = 1'b1;
        sa[2] = 8'd200; sb[2] = 8'd3;   ss[2] = 1'b0;
        nacc   = 0;
        prev_v = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc_now = 1'b0;
            if (nacc < 3) begin
                in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    a = sa[nacc]; b = sb[nacc]; is_signed = ss[nacc]; acc_en = 1'b1;
                    acc_now = 1'b1;
                end else begin
                    a = W'($urandom); b = W'($urandom);
                    is_signed = 1'($urandom); acc_en = 1'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                op.p = prod_of(sa[nacc], sb[nacc], ss[nacc]);
                op.s = ss[nacc];
                op.en = 1'b1;
                pend.push_back(op);
                nacc++;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_accept got=%b want=0", in_ready); end
            end
            if (out_valid === 1'b1) begin
                pulses.push_back(cyc);
                total++; if (prev_v || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_strobe prev=%b ready=%b want 0/0", prev_v, in_ready); end
                if (pend.size() > 0) begin
                    op = pend.pop_front();
                    model_op(op.p, op.s, op.en, 1'b0);
                    total++; if (prod !== 16'(op.p) || acc !== 24'(macc[0]) || acc16 !== 16'(macc[1])) begin
                        bad++; $display("FAIL b2b_result prod=%h acc=%h/%h want %h %h/%h", prod, acc, acc16, 16'(op.p), 24'(macc[0]), 16'(macc[1]));
                    end
                end
            end
            prev_v = out_valid;
        end
        in_valid = 1'b0;
        total++; if (pulses.size() != 3) begin bad++; $display("FAIL b2b_pulse_count got=%0d want=3", pulses.size()); end
        for (int i = 1; i < pulses.size(); i++) begin
            total++; if (pulses[i] - pulses[i-1] != int'(W) + 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", pulses[i] - pulses[i-1], W + 3); end
        end
    endtask

    task automatic test_reset_midop();
        bit ok; int lat;
        bit saw_v;
        @(posedge clk); #1;
        while (in_ready !== 1'b1) begin @(posedge clk); #1; end
        a = 8'd9; b = 8'd9; is_signed = 1'b0; acc_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        saw_v = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw_v = 1'b1;
        end
        total++; if (saw_v || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_strobe got=%b want=0", saw_v | out_valid); end
        total++; if (prod !== 16'h0 || acc !== 24'h0 || acc16 !== 16'h0) begin bad++; $display("FAIL midrst_clear prod=%h acc=%h want=0", prod, acc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd3, 8'd4, 1'b0, 1'b0, 1'b0, ok, lat);
        model_op(prod_of(8'd3, 8'd4, 1'b0), 1'b0, 1'b0, 1'b0);
        total++; if (!ok || lat != int'(W) + 1 || prod !== 16'd12) begin bad++; $display("FAIL midrst_recover prod=%0d lat=%0d ok=%b want=12 lat=%0d", prod, lat, ok, W + 1); end
    endtask

    task automatic test_random();
        bit ok; int lat;
        logic [W-1:0] x, y;
        bit s, en, c;
        longint p;
        for (int n = 0; n < 24; n++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            s  = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 5) == 0);
            run_op(x, y, s, en, c, ok, lat);
            p = prod_of(x, y, s);
            model_op(p, s, en, c);
            total++; if (!ok || lat != int'(W) + 1 || prod !== 16'(p) || p16 !== 16'(p)) begin
                bad++; $display("FAIL rand_prod n=%0d x=%h y=%h s=%b got=%h lat=%0d want=%h", n, x, y, s, prod, lat, 16'(p));
            end
            total++; if (acc !== 24'(macc[0]) || overflow !== movf[0] || acc16 !== 16'(macc[1]) || ov16 !== movf[1]) begin
                bad++; $display("FAIL rand_acc n=%0d got=%h/%b %h/%b want=%h/%b %h/%b", n, acc, overflow, acc16, ov16,
                                24'(macc[0]), movf[0], 16'(macc[1]), movf[1]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        is_signed = 1'b0; acc_en = 1'b0; clr = 1'b0;
        model_reset();
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_unsigned_full();
        test_signed();
        test_accum_chain();
        test_overflow_clr();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
